// File: rtl/duck_pkg.sv
// Shared duck sprite engine types: state encoding, sheet frame indices, sheet geometry.
// Combinational only; no timing or flow-control behaviour of its own.
package duck_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FLY  = 2'd1,
      SHOT = 2'd2,
      FALL = 2'd3
   } duck_state_t;

   localparam logic [2:0] FR_SHOT = 3'd3;
   localparam logic [2:0] FR_FALL = 3'd4;

   // Default sheet stride: 5 frames of 64 pixels laid side by side.
   localparam int unsigned SHEET_W = 64 * 5;

   function automatic int unsigned sheet_width(input int unsigned sprite_w, input int unsigned num_frames);
      return sprite_w * num_frames;
   endfunction

endpackage

// File: rtl/duck_sprite_engine_frame_tick_sync.sv
// Brings the vsync-rate frame_clk into the Clk domain and emits a one-Clk pulse per rising edge.
// Pulse appears 2 Clk after frame_clk is first sampled high; no backpressure.
module frame_tick_sync (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_frame_clk,
   output logic o_frame_tick
);

   logic [1:0] r_sync;
   logic       r_prev;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_sync <= 2'b00;
         r_prev <= 1'b0;
      end else begin
         r_sync <= {r_sync[0], i_frame_clk};
         r_prev <= r_sync[1];
      end
   end

   assign o_frame_tick = r_sync[1] & ~r_prev;

endmodule

// File: rtl/duck_sprite_engine.sv
// Duck position/animation/hit-fall FSM advanced per frame tick, plus per-pixel sheet address and box flag.
// duck_addr is combinational from DrawX/DrawY; is_duck trails the box flag by PIPE_DLY Clk.
module duck_sprite_engine
   import duck_pkg::*;
#(
   parameter int unsigned SPRITE_W   = 64,
   parameter int unsigned SPRITE_H   = 64,
   parameter int unsigned NUM_FRAMES = 5,
   parameter int unsigned SCREEN_W   = 640,
   parameter int unsigned FLOOR_Y    = 400,
   parameter int unsigned START_X    = 288,
   parameter int unsigned START_Y    = 300,
   parameter int unsigned SPEED      = 2,
   parameter int unsigned ANIM_DIV   = 8,
   parameter int unsigned SHOT_HOLD  = 30,
   parameter int unsigned FALL_SPEED = 4,
   parameter int unsigned PIPE_DLY   = 2
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        frame_clk,
   input  logic [9:0]  DrawX,
   input  logic [9:0]  DrawY,
   input  logic        start,
   input  logic        shot,
   output logic        is_duck,
   output logic [18:0] duck_addr,
   output logic [9:0]  duck_x,
   output logic [9:0]  duck_y,
   output logic [1:0]  duck_state,
   output logic        done
);

   localparam int unsigned       SHEET_STRIDE = sheet_width(SPRITE_W, NUM_FRAMES);
   localparam logic signed [10:0] X_MAX       = 11'(SCREEN_W - SPRITE_W);
   localparam logic signed [10:0] Y_MAX       = 11'(FLOOR_Y - SPRITE_H);
   localparam logic signed [10:0] SPD         = 11'(SPEED);
   localparam logic [9:0]        X0           = 10'(START_X);
   localparam logic [9:0]        Y0           = 10'(START_Y);
   localparam logic [9:0]        FLOOR        = 10'(FLOOR_Y);
   localparam logic [9:0]        FALL_D       = 10'(FALL_SPEED);
   localparam logic [7:0]        ANIM_LAST    = 8'(ANIM_DIV - 1);
   localparam logic [7:0]        HOLD_LAST    = 8'(SHOT_HOLD - 1);

   duck_state_t        r_state, w_state_nx;
   logic [9:0]         r_x, r_y, w_x_nx, w_y_nx;
   logic signed [10:0] r_vx, r_vy, w_vx_nx, w_vy_nx;
   logic [2:0]         r_frame, w_frame_nx;
   logic [7:0]         r_anim_cnt, w_anim_nx, r_hold_cnt, w_hold_nx;
   logic               r_done, w_done_nx;
   logic               w_tick;
   logic signed [10:0] w_nx, w_ny;
   logic [9:0]         w_fall_y;

   frame_tick_sync u_tick (
      .i_clk        (Clk),
      .i_reset      (Reset),
      .i_frame_clk  (frame_clk),
      .o_frame_tick (w_tick)
   );

   assign w_nx     = $signed({1'b0, r_x}) + r_vx;
   assign w_ny     = $signed({1'b0, r_y}) + r_vy;
   assign w_fall_y = r_y + FALL_D;

   always_comb begin
      w_state_nx = r_state;
      w_x_nx     = r_x;
      w_y_nx     = r_y;
      w_vx_nx    = r_vx;
      w_vy_nx    = r_vy;
      w_frame_nx = r_frame;
      w_anim_nx  = r_anim_cnt;
      w_hold_nx  = r_hold_cnt;
      w_done_nx  = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_state_nx = FLY;
               w_x_nx     = X0;
               w_y_nx     = Y0;
               w_vx_nx    = SPD;
               w_vy_nx    = -SPD;
               w_frame_nx = 3'd0;
               w_anim_nx  = 8'd0;
               w_hold_nx  = 8'd0;
            end
         end
         FLY: begin
            // A hit freezes the duck even if it coincides with a frame tick.
            if (shot) begin
               w_state_nx = SHOT;
               w_frame_nx = FR_SHOT;
               w_hold_nx  = 8'd0;
            end else if (w_tick) begin
               if (w_nx < 0 || w_nx > X_MAX) w_vx_nx = -r_vx;
               else                          w_x_nx  = w_nx[9:0];
               if (w_ny < 0 || w_ny > Y_MAX) w_vy_nx = -r_vy;
               else                          w_y_nx  = w_ny[9:0];
               if (r_anim_cnt == ANIM_LAST) begin
                  w_anim_nx  = 8'd0;
                  w_frame_nx = (r_frame == 3'd2) ? 3'd0 : r_frame + 3'd1;
               end else begin
                  w_anim_nx  = r_anim_cnt + 8'd1;
               end
            end
         end
         SHOT: begin
            if (w_tick) begin
               if (r_hold_cnt == HOLD_LAST) begin
                  w_state_nx = FALL;
                  w_frame_nx = FR_FALL;
               end else begin
                  w_hold_nx  = r_hold_cnt + 8'd1;
               end
            end
         end
         FALL: begin
            if (w_tick) begin
               if (w_fall_y >= FLOOR) begin
                  w_y_nx     = FLOOR;
                  w_done_nx  = 1'b1;
                  w_state_nx = IDLE;
               end else begin
                  w_y_nx     = w_fall_y;
               end
            end
         end
         default: w_state_nx = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state    <= IDLE;
         r_x        <= X0;
         r_y        <= Y0;
         r_vx       <= SPD;
         r_vy       <= -SPD;
         r_frame    <= 3'd0;
         r_anim_cnt <= 8'd0;
         r_hold_cnt <= 8'd0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_state_nx;
         r_x        <= w_x_nx;
         r_y        <= w_y_nx;
         r_vx       <= w_vx_nx;
         r_vy       <= w_vy_nx;
         r_frame    <= w_frame_nx;
         r_anim_cnt <= w_anim_nx;
         r_hold_cnt <= w_hold_nx;
         r_done     <= w_done_nx;
      end
   end

   // 11-bit compares so x+SPRITE_W-1 near the right edge cannot wrap.
   logic [10:0] w_dx, w_dy;
   logic        w_in_x, w_in_y, w_box;

   assign w_dx   = {1'b0, DrawX} - {1'b0, r_x};
   assign w_dy   = {1'b0, DrawY} - {1'b0, r_y};
   assign w_in_x = ({1'b0, DrawX} >= {1'b0, r_x}) && ({1'b0, DrawX} <= {1'b0, r_x} + 11'(SPRITE_W - 1));
   assign w_in_y = ({1'b0, DrawY} >= {1'b0, r_y}) && ({1'b0, DrawY} <= {1'b0, r_y} + 11'(SPRITE_H - 1));
   assign w_box  = (r_state != IDLE) && w_in_x && w_in_y;

   assign duck_addr = w_box ? (19'(w_dy) * 19'(SHEET_STRIDE) + 19'(r_frame) * 19'(SPRITE_W) + 19'(w_dx))
                            : 19'd0;

   generate
      if (PIPE_DLY == 0) begin : g_no_pipe
         assign is_duck = w_box;
      end else begin : g_pipe
         logic [PIPE_DLY-1:0] r_pipe;
         always_ff @(posedge Clk) begin
            if (Reset) r_pipe <= '0;
            else       r_pipe <= PIPE_DLY'({r_pipe, w_box});
         end
         assign is_duck = r_pipe[PIPE_DLY-1];
      end
   endgenerate

   assign duck_x     = r_x;
   assign duck_y     = r_y;
   assign duck_state = r_state;
   assign done       = r_done;

endmodule
